// File: rtl/awg_pkg.sv
// Shared types and width helpers for the AWG playback engine.
// Optional feature macro: AWG_TLAST_EN (adds m00_axis_tlast on the stream).
package awg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } awg_state_t;

    // Ceiling log2, never below 1 so single-entry selects still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int word_w(input int sample_w, input int spw);
        return sample_w * spw;
    endfunction

    function automatic int tdata_w(input int sample_w, input int spw, input int num_banks);
        return sample_w * spw * num_banks;
    endfunction

endpackage

// File: rtl/awg_stream_fifo.sv
// Small synchronous output FIFO with an AXI4-Stream style read side and a flush.
// A write is accepted while full only if a pop happens in the same cycle; the
// upstream credit check guarantees it never writes into a truly full FIFO.
module awg_stream_fifo
    import awg_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_flush,
    input  logic                        i_wr_en,
    input  logic [WIDTH-1:0]            i_wr_data,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_pop   = o_valid && i_ready;
    assign w_push  = i_wr_en && ((r_count != CNT_W'(DEPTH)) || w_pop);

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/awg_playback_engine.sv
// Multi-bank waveform playback engine: lockstep bank reads, segment looping,
// triggered start, abort, and a back-pressured AXI4-Stream output.
// Optional feature macro: AWG_TLAST_EN (tlast marks row end_addr of each pass).
module awg_playback_engine
    import awg_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int SPW        = 8,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_W     = 16,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = READ_LAT + 2
) (
    input  logic                                     m00_axis_aclk,
    input  logic                                     m00_axis_areset,
    input  logic                                     wr_en,
    input  logic [clog2(NUM_BANKS)-1:0]              wr_bank,
    input  logic [ADDR_W-1:0]                        wr_row,
    input  logic [clog2(SPW)-1:0]                    wr_col,
    input  logic [SAMPLE_W-1:0]                      wr_data,
    input  logic [ADDR_W-1:0]                        start_addr,
    input  logic [ADDR_W-1:0]                        end_addr,
    input  logic [15:0]                              loop_count,
    input  logic                                     trig_mode,
    input  logic                                     arm,
    input  logic                                     trigger,
    input  logic                                     abort,
    output logic [tdata_w(SAMPLE_W,SPW,NUM_BANKS)-1:0] m00_axis_tdata,
    output logic                                     m00_axis_tvalid,
    input  logic                                     m00_axis_tready,
`ifdef AWG_TLAST_EN
    output logic                                     m00_axis_tlast,
`endif
    output logic                                     busy,
    output logic                                     done,
    output logic                                     cfg_err
);
    localparam int WORD_W  = word_w(SAMPLE_W, SPW);
    localparam int TDATA_W = tdata_w(SAMPLE_W, SPW, NUM_BANKS);
    localparam int BANK_W  = clog2(NUM_BANKS);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_W   = clog2(FIFO_DEPTH + 1);
    localparam int IF_W    = clog2(READ_LAT + 2);
`ifdef AWG_TLAST_EN
    localparam int FIFO_W  = TDATA_W + 1;
`else
    localparam int FIFO_W  = TDATA_W;
`endif

    awg_state_t          r_state;
    awg_state_t          w_state_next;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_end;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_loops;
    logic [15:0]         r_pass;
    logic                r_cfg_err;
    logic                r_iss_vld;
    logic [ADDR_W-1:0]   r_iss_addr;
    logic [READ_LAT-1:0] r_rd_vld;
    logic [TDATA_W-1:0]  w_rd_data;
    logic [IF_W-1:0]     w_in_flight;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [FIFO_W-1:0]   w_fifo_in;
    logic [FIFO_W-1:0]   w_fifo_out;
    logic                w_pop;
    logic                w_fetch;
    logic                w_final;
    logic                w_arm_ok;
    logic                w_arm_bad;
    logic                w_done;
`ifdef AWG_TLAST_EN
    logic                r_iss_last;
    logic [READ_LAT-1:0] r_rd_last;
`endif

    assign w_pop   = m00_axis_tvalid && m00_axis_tready;
    assign w_final = (r_loops != 16'd0) && (r_pass == r_loops - 16'd1) && (r_addr == r_end);
    // A pop this cycle frees a slot, so it counts as credit for the next fetch.
    assign w_fetch = (r_state == PLAY) && !abort &&
                     ((32'(w_fifo_count) + 32'(w_in_flight)) < (32'(FIFO_DEPTH) + 32'(w_pop)));
    assign busy    = (r_state != IDLE);
    assign done    = w_done;
    assign cfg_err = r_cfg_err;

    // Count reads issued but not yet written into the FIFO.
    always_comb begin
        w_in_flight = IF_W'(r_iss_vld);
        for (int k = 0; k < READ_LAT; k++) w_in_flight = w_in_flight + IF_W'(r_rd_vld[k]);
    end

    // Next-state and control strobes; abort always wins.
    always_comb begin
        w_state_next = r_state;
        w_arm_ok     = 1'b0;
        w_arm_bad    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!abort && arm) begin
                    if (end_addr < start_addr) begin
                        w_arm_bad = 1'b1;
                    end else begin
                        w_arm_ok     = 1'b1;
                        w_state_next = trig_mode ? ARMED : PLAY;
                    end
                end
            end
            ARMED: begin
                if (abort)        w_state_next = IDLE;
                else if (trigger) w_state_next = PLAY;
            end
            PLAY: begin
                if (abort)                   w_state_next = IDLE;
                else if (w_fetch && w_final) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_fifo_count == '0 && w_in_flight == '0) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) r_state <= IDLE;
        else                 r_state <= w_state_next;
    end

    // Segment config latch, fetch address walk and pass counting.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            r_start   <= '0;
            r_end     <= '0;
            r_addr    <= '0;
            r_loops   <= '0;
            r_pass    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_arm_bad) r_cfg_err <= 1'b1;
            if (w_arm_ok) begin
                r_start   <= start_addr;
                r_end     <= end_addr;
                r_addr    <= start_addr;
                r_loops   <= loop_count;
                r_pass    <= '0;
                r_cfg_err <= 1'b0;
            end else if (w_fetch) begin
                if (r_addr == r_end) begin
                    r_addr <= r_start;
                    r_pass <= r_pass + 16'd1;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    // Issue register plus valid (and tlast) tracking down the read pipeline.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            r_iss_vld  <= 1'b0;
            r_iss_addr <= '0;
            r_rd_vld   <= '0;
`ifdef AWG_TLAST_EN
            r_iss_last <= 1'b0;
            r_rd_last  <= '0;
`endif
        end else begin
            r_iss_addr <= r_addr;
            if (abort) begin
                r_iss_vld <= 1'b0;
                r_rd_vld  <= '0;
            end else begin
                r_iss_vld   <= w_fetch;
                r_rd_vld[0] <= r_iss_vld;
                for (int k = 1; k < READ_LAT; k++) r_rd_vld[k] <= r_rd_vld[k-1];
            end
`ifdef AWG_TLAST_EN
            r_iss_last   <= (r_addr == r_end);
            r_rd_last[0] <= r_iss_last;
            for (int k = 1; k < READ_LAT; k++) r_rd_last[k] <= r_rd_last[k-1];
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [WORD_W-1:0] r_mem [DEPTH];
            logic [WORD_W-1:0] r_q   [READ_LAT];
            // Lane write, read-first registered read, then the output register chain.
            always_ff @(posedge m00_axis_aclk) begin
                if (wr_en && wr_bank == BANK_W'(gi))
                    r_mem[wr_row][wr_col*SAMPLE_W +: SAMPLE_W] <= wr_data;
                r_q[0] <= r_mem[r_iss_addr];
                for (int k = 1; k < READ_LAT; k++) r_q[k] <= r_q[k-1];
            end
            assign w_rd_data[gi*WORD_W +: WORD_W] = r_q[READ_LAT-1];
        end
    endgenerate

`ifdef AWG_TLAST_EN
    assign w_fifo_in = {r_rd_last[READ_LAT-1], w_rd_data};
    assign {m00_axis_tlast, m00_axis_tdata} = w_fifo_out;
`else
    assign w_fifo_in = w_rd_data;
    assign m00_axis_tdata = w_fifo_out;
`endif

    awg_stream_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (m00_axis_aclk),
        .i_rst     (m00_axis_areset),
        .i_flush   (abort),
        .i_wr_en   (r_rd_vld[READ_LAT-1]),
        .i_wr_data (w_fifo_in),
        .o_data    (w_fifo_out),
        .o_valid   (m00_axis_tvalid),
        .i_ready   (m00_axis_tready),
        .o_count   (w_fifo_count)
    );

endmodule

// File: tb/tb_awg_playback_engine.sv
// Directed bench for awg_playback_engine with an expected-word scoreboard.
// Bank b, row r, lane c is loaded with r*8 + c + b*4096 so bank order is visible.
module tb_awg_playback_engine;
    localparam int SAMPLE_W = 16;
    localparam int SPW      = 8;
    localparam int NB       = 2;
    localparam int ADDR_W   = 16;
    localparam int READ_LAT = 2;
    localparam int TW       = NB * SPW * SAMPLE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [0:0]        wr_bank;
    logic [ADDR_W-1:0] wr_row;
    logic [2:0]        wr_col;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic [15:0]       loop_count;
    logic              trig_mode;
    logic              arm;
    logic              trigger;
    logic              abort;
    logic [TW-1:0]     tdata;
    logic              tvalid;
    logic              tready;
    logic              busy;
    logic              done;
    logic              cfg_err;
`ifdef AWG_TLAST_EN
    logic              tlast;
`endif

    int total = 0;
    int bad = 0;
    int mon_words = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int cyc = 0;
    int first_hs = -1;
    int last_hs = -1;
    bit chk_stall = 1'b0;
    logic prev_stall = 1'b0;
    logic [TW-1:0] prev_data = '0;
    logic [TW:0] exp_q [$];
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    awg_playback_engine #(
        .SAMPLE_W (SAMPLE_W), .SPW (SPW), .NUM_BANKS (NB),
        .ADDR_W (ADDR_W), .READ_LAT (READ_LAT), .FIFO_DEPTH (READ_LAT + 2)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (rst),
        .wr_en           (wr_en),
        .wr_bank         (wr_bank),
        .wr_row          (wr_row),
        .wr_col          (wr_col),
        .wr_data         (wr_data),
        .start_addr      (start_addr),
        .end_addr        (end_addr),
        .loop_count      (loop_count),
        .trig_mode       (trig_mode),
        .arm             (arm),
        .trigger         (trigger),
        .abort           (abort),
        .m00_axis_tdata  (tdata),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tready (tready),
`ifdef AWG_TLAST_EN
        .m00_axis_tlast  (tlast),
`endif
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    task automatic check_word(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] row_word(input int row);
        logic [TW-1:0] w;
        w = '0;
        for (int b = 0; b < NB; b++)
            for (int c = 0; c < SPW; c++)
                w[(b*SPW + c)*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(row*8 + c + b*4096);
        return w;
    endfunction

    task automatic push_seg(input int s, input int e, input int passes);
        for (int p = 0; p < passes; p++)
            for (int r = s; r <= e; r++)
                exp_q.push_back({(r == e), row_word(r)});
    endtask

    // Stream monitor: scoreboard pop on handshake, stall-hold check, done count.
    always @(negedge clk) begin
        logic [TW:0] e;
        if (done) done_cnt++;
        if (chk_stall && prev_stall) begin
            check_bit("stall_valid", tvalid, 1'b1);
            check_word("stall_data", tdata, prev_data);
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        if (tvalid && tready) begin
            mon_words++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL extra_word observed=%h expected=none", tdata);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_word("data", tdata, e[TW-1:0]);
`ifdef AWG_TLAST_EN
                check_bit("tlast", tlast, e[TW]);
`endif
                $display("word %0d data=%h", mon_words, tdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int s, input int e, input int l, input bit tm);
        start_addr = ADDR_W'(s);
        end_addr   = ADDR_W'(e);
        loop_count = 16'(l);
        trig_mode  = tm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic measure_latency(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tvalid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input bit toggle);
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            if (toggle) tready = pat[n % 4];
            n++;
        end
        tready = 1'b1;
        check_bit("idle_reached", busy, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        int n;
        int seen;
        rst = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_row = '0; wr_col = '0; wr_data = '0;
        start_addr = '0; end_addr = '0; loop_count = '0; trig_mode = 1'b0;
        arm = 1'b0; trigger = 1'b0; abort = 1'b0; tready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check_bit("reset_tvalid", tvalid, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_cfg_err", cfg_err, 1'b0);
        check_word("reset_tdata", tdata, '0);
        tick();
        rst = 1'b0;
        tick();

        // Load rows 0..7 of both banks.
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < SPW; c++) begin
                    wr_en = 1'b1; wr_bank = 1'(b); wr_row = ADDR_W'(r);
                    wr_col = 3'(c); wr_data = 16'(r*8 + c + b*4096);
                    tick();
                end
        wr_en = 1'b0;
        tick();

        // Two passes of rows 0..3 at full rate.
        first_hs = -1;
        base = mon_words;
        push_seg(0, 3, 2);
        do_arm(0, 3, 2, 1'b0);
        measure_latency(lat);
        check_int("latency_arm", lat, READ_LAT + 2);
        wait_idle(1'b0);
        exp_done++;
        check_int("t1_words", mon_words - base, 8);
        check_int("t1_throughput", last_hs - first_hs, 7);
        check_int("t1_done", done_cnt, exp_done);
        check_int("t1_queue", exp_q.size(), 0);
        $display("run1 complete words=%0d", mon_words - base);

        // Same run with 1,0,0,1 back-pressure.
        base = mon_words;
        chk_stall = 1'b1;
        push_seg(0, 3, 2);
        do_arm(0, 3, 2, 1'b0);
        wait_idle(1'b1);
        tick();
        chk_stall = 1'b0;
        exp_done++;
        check_int("t2_words", mon_words - base, 8);
        check_int("t2_done", done_cnt, exp_done);
        check_int("t2_queue", exp_q.size(), 0);
        $display("run2 complete words=%0d", mon_words - base);

        // Triggered start: nothing before trigger, fixed latency after.
        push_seg(0, 1, 1);
        do_arm(0, 1, 1, 1'b1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tvalid) seen++;
        end
        check_int("armed_no_tvalid", seen, 0);
        check_bit("armed_busy", busy, 1'b1);
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        measure_latency(lat);
        check_int("latency_trigger", lat, READ_LAT + 2);
        wait_idle(1'b0);
        exp_done++;
        check_int("t3_done", done_cnt, exp_done);
        $display("run3 complete");

        // Invalid then valid arm; start==end style short segment.
        do_arm(5, 4, 1, 1'b0);
        @(negedge clk);
        check_bit("cfg_err_set", cfg_err, 1'b1);
        check_bit("cfg_err_idle", busy, 1'b0);
        push_seg(4, 5, 1);
        push_seg(6, 6, 2);
        do_arm(4, 5, 1, 1'b0);
        @(negedge clk);
        check_bit("cfg_err_clear", cfg_err, 1'b0);
        wait_idle(1'b0);
        do_arm(6, 6, 2, 1'b0);
        wait_idle(1'b0);
        exp_done += 2;
        check_int("t4_done", done_cnt, exp_done);
        check_int("t4_queue", exp_q.size(), 0);
        $display("run4 complete");

        // Infinite loop, abort right after the 20th word.
        base = mon_words;
        push_seg(0, 3, 5);
        do_arm(0, 3, 0, 1'b0);
        n = 0;
        while (mon_words != base + 19 && n < 300) begin
            tick();
            n++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_bit("abort_tvalid", tvalid, 1'b0);
        check_bit("abort_busy", busy, 1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tvalid) seen++;
        end
        check_int("abort_stays_empty", seen, 0);
        check_int("abort_words", mon_words - base, 20);
        check_int("abort_no_done", done_cnt, exp_done);
        check_int("abort_queue", exp_q.size(), 0);
        tick();
        push_seg(0, 3, 1);
        do_arm(0, 3, 1, 1'b0);
        wait_idle(1'b0);
        exp_done++;
        check_int("rearm_done", done_cnt, exp_done);
        check_int("rearm_queue", exp_q.size(), 0);
        $display("run5 complete");

        // Reset asserted mid-play; memory must survive.
        base = mon_words;
        push_seg(0, 3, 3);
        do_arm(0, 3, 0, 1'b0);
        n = 0;
        while (mon_words != base + 5 && n < 300) begin
            tick();
            n++;
        end
        rst = 1'b1;
        #1;
        check_bit("midrst_tvalid", tvalid, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_done", done, 1'b0);
        check_word("midrst_tdata", tdata, '0);
        exp_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        push_seg(0, 3, 1);
        do_arm(0, 3, 1, 1'b0);
        wait_idle(1'b0);
        exp_done++;
        check_int("postrst_done", done_cnt, exp_done);
        check_int("postrst_queue", exp_q.size(), 0);
        $display("run6 complete");

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
